// File: rtl/me_frame_loader.sv
// me_frame_loader
//   Feeds the motion-estimation engine. A byte-serial pixel stream (16x16 current
//   block followed by the 32x32 reference window) is packed LSB-first, 8 pixels per
//   64-bit word. The words are written into the engine's cur and ref memories. After
//   the last reference word the loader pulses go, then blocks any new load until the
//   engine reports me_done.
//
// Ports
//   clk, reset                     clock, async active-high reset
//   start_load                     1-cycle load request, honoured in IDLE only
//   pix_valid/pix_data/pix_ready   byte stream handshake (accept = valid & ready)
//   address/data/write_enable_cur  cur memory write port (1-cycle strobe per word)
//   address/data/write_enable_ref  ref memory write port (1-cycle strobe per word)
//   go                             1-cycle engine start pulse
//   me_done                        engine completion, honoured in WAIT_DONE only
//   busy                           high whenever not IDLE
module me_frame_loader #(
    parameter int PIX_W     = 8,
    parameter int WORD_PIX  = 8,
    parameter int CUR_WORDS = 32,
    parameter int REF_WORDS = 128,
    parameter int CUR_AW    = 5,
    parameter int REF_AW    = 7
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      start_load,
    input  logic                      pix_valid,
    input  logic [PIX_W-1:0]          pix_data,
    output logic                      pix_ready,
    output logic [CUR_AW-1:0]         address_write_cur,
    output logic [PIX_W*WORD_PIX-1:0] data_write_cur,
    output logic                      write_enable_cur,
    output logic [REF_AW-1:0]         address_write_ref,
    output logic [PIX_W*WORD_PIX-1:0] data_write_ref,
    output logic                      write_enable_ref,
    output logic                      go,
    input  logic                      me_done,
    output logic                      busy
);
    localparam int WORD_W = PIX_W * WORD_PIX;
    localparam int BC_W   = $clog2(WORD_PIX);
    // One counter serves both phases; sized for the larger memory.
    localparam int WC_W   = (REF_AW > CUR_AW) ? REF_AW : CUR_AW;

    typedef enum logic [2:0] {
        IDLE,
        LOAD_CUR,
        LOAD_REF,
        START,
        WAIT_DONE
    } state_t;

    state_t                  state, state_nxt;
    logic [BC_W-1:0]         byte_cnt;
    logic [WC_W-1:0]         word_cnt;
    // Holds bytes 0..WORD_PIX-2; the final byte goes straight from pix_data into the word.
    logic [WORD_W-PIX_W-1:0] pack;
    logic                    accept;
    logic                    word_full;
    logic                    last_cur;
    logic                    last_ref;
    logic [WORD_W-1:0]       full_word;

    assign accept    = pix_valid & pix_ready;
    assign word_full = accept && (byte_cnt == BC_W'(WORD_PIX - 1));
    assign last_cur  = word_full && (word_cnt == WC_W'(CUR_WORDS - 1));
    assign last_ref  = word_full && (word_cnt == WC_W'(REF_WORDS - 1));
    assign full_word = {pix_data, pack};
    assign busy      = (state != IDLE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        pix_ready = 1'b0;
        go        = 1'b0;
        case (state)
            IDLE:      if (start_load) state_nxt = LOAD_CUR;
            LOAD_CUR: begin
                pix_ready = 1'b1;
                if (last_cur) state_nxt = LOAD_REF;
            end
            LOAD_REF: begin
                pix_ready = 1'b1;
                if (last_ref) state_nxt = START;
            end
            START: begin
                go        = 1'b1;
                state_nxt = WAIT_DONE;
            end
            WAIT_DONE: if (me_done) state_nxt = IDLE;
            default:   state_nxt = IDLE;
        endcase
    end

    // Packing and write port. The strobe is registered, so it appears the cycle after
    // the completing byte; address/data hold their value between strobes.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            byte_cnt          <= '0;
            word_cnt          <= '0;
            pack              <= '0;
            write_enable_cur  <= 1'b0;
            write_enable_ref  <= 1'b0;
            address_write_cur <= '0;
            address_write_ref <= '0;
            data_write_cur    <= '0;
            data_write_ref    <= '0;
        end else begin
            write_enable_cur <= 1'b0;
            write_enable_ref <= 1'b0;
            if (accept) begin
                if (word_full) begin
                    byte_cnt <= '0;
                    if (state == LOAD_CUR) begin
                        write_enable_cur  <= 1'b1;
                        address_write_cur <= word_cnt[CUR_AW-1:0];
                        data_write_cur    <= full_word;
                        // Clearing on the last cur word makes the first ref word land at 0.
                        word_cnt          <= last_cur ? '0 : word_cnt + WC_W'(1);
                    end else begin
                        write_enable_ref  <= 1'b1;
                        address_write_ref <= word_cnt[REF_AW-1:0];
                        data_write_ref    <= full_word;
                        word_cnt          <= last_ref ? '0 : word_cnt + WC_W'(1);
                    end
                end else begin
                    byte_cnt                             <= byte_cnt + BC_W'(1);
                    pack[int'(byte_cnt)*PIX_W +: PIX_W] <= pix_data;
                end
            end
        end
    end
endmodule

// File: tb/tb_me_frame_loader.sv
// Bench for me_frame_loader. Every completed word is predicted from the stream index
// and pushed to a scoreboard; each write strobe pops and compares one entry.
module tb_me_frame_loader;
    logic        clk = 1'b0;
    logic        reset, start_load, pix_valid, me_done;
    logic [7:0]  pix_data;
    logic        pix_ready, write_enable_cur, write_enable_ref, go, busy;
    logic [4:0]  address_write_cur;
    logic [6:0]  address_write_ref;
    logic [63:0] data_write_cur, data_write_ref;

    me_frame_loader dut (
        .clk(clk), .reset(reset), .start_load(start_load),
        .pix_valid(pix_valid), .pix_data(pix_data), .pix_ready(pix_ready),
        .address_write_cur(address_write_cur), .data_write_cur(data_write_cur),
        .write_enable_cur(write_enable_cur),
        .address_write_ref(address_write_ref), .data_write_ref(data_write_ref),
        .write_enable_ref(write_enable_ref),
        .go(go), .me_done(me_done), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          is_ref;
        int          addr;
        logic [63:0] data;
    } exp_t;

    exp_t        sbq[$];
    exp_t        mon_e;
    logic [63:0] mem_cur[32];
    logic [63:0] mem_ref[128];
    logic [63:0] mdl_word;
    int          n_wcur, n_wref, n_go;
    int          n_chk, n_pass;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, obs, exp);
    endtask

    function automatic logic [63:0] exp_word(input int base, input int b0);
        logic [63:0] w;
        for (int k = 0; k < 8; k++) w[8*k +: 8] = 8'((b0 + k + base) & 255);
        return w;
    endfunction

    // Write-port monitor
    always @(negedge clk) begin
        if (write_enable_cur && write_enable_ref) chk("dual_strobe", 64'd1, 64'd0);
        if (write_enable_cur || write_enable_ref) begin
            if (sbq.size() == 0) begin
                chk("spurious_strobe", 64'd1, 64'd0);
            end else begin
                mon_e = sbq.pop_front();
                chk("wr_mem_sel", {63'd0, write_enable_ref}, {63'd0, mon_e.is_ref});
                if (write_enable_ref) begin
                    chk("wr_addr_ref", 64'(address_write_ref), 64'(mon_e.addr));
                    chk("wr_data_ref", data_write_ref, mon_e.data);
                end else begin
                    chk("wr_addr_cur", 64'(address_write_cur), 64'(mon_e.addr));
                    chk("wr_data_cur", data_write_cur, mon_e.data);
                end
            end
            if (write_enable_ref) begin
                mem_ref[address_write_ref] = data_write_ref;
                n_wref++;
            end else begin
                mem_cur[address_write_cur] = data_write_cur;
                n_wcur++;
            end
        end
        if (go) n_go++;
    end

    task automatic pulse_start();
        start_load = 1'b1;
        @(posedge clk); #1;
        start_load = 1'b0;
    endtask

    // Stream bytes with index first..last-1; byte b carries (b+base) mod 256.
    task automatic send(input int first, input int last, input int base, input bit gaps);
        int b     = first;
        int guard = 0;
        bit acc;
        while (b < last && guard < 20000) begin
            pix_valid = gaps ? ($urandom_range(0, 1) == 1) : 1'b1;
            pix_data  = 8'((b + base) & 255);
            @(negedge clk);
            acc = pix_valid && pix_ready;
            @(posedge clk); #1;
            if (acc) begin
                mdl_word[8*(b%8) +: 8] = pix_data;
                if (b % 8 == 7)
                    sbq.push_back('{is_ref: (b >= 256),
                                    addr:   ((b < 256) ? b : b - 256) / 8,
                                    data:   mdl_word});
                b++;
            end
            guard++;
        end
        pix_valid = 1'b0;
        if (guard >= 20000) chk("send_timeout", 64'(b), 64'(last));
    endtask

    task automatic clear_mem();
        foreach (mem_cur[i]) mem_cur[i] = '0;
        foreach (mem_ref[i]) mem_ref[i] = '0;
    endtask

    // Called right after the final byte is accepted: go and the last write follow.
    task automatic post_load(input string tag, input int base, input int wc0, input int wr0, input int g0);
        repeat (3) @(posedge clk);
        #1;
        chk({tag, "_go_count"},  64'(n_go - g0),    64'd1);
        chk({tag, "_cur_count"}, 64'(n_wcur - wc0), 64'd32);
        chk({tag, "_ref_count"}, 64'(n_wref - wr0), 64'd128);
        chk({tag, "_sb_empty"},  64'(sbq.size()),   64'd0);
        chk({tag, "_busy"},      64'(busy),         64'd1);
        chk({tag, "_cur0"},   mem_cur[0],   exp_word(base, 0));
        chk({tag, "_cur31"},  mem_cur[31],  exp_word(base, 248));
        chk({tag, "_ref0"},   mem_ref[0],   exp_word(base, 256));
        chk({tag, "_ref127"}, mem_ref[127], exp_word(base, 256 + 1016));
    endtask

    int wc0, wr0, g0;

    initial begin
        reset = 1'b1; start_load = 1'b0; pix_valid = 1'b0; pix_data = '0; me_done = 1'b0;
        n_chk = 0; n_pass = 0; n_wcur = 0; n_wref = 0; n_go = 0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ctrl", 64'({pix_ready, write_enable_cur, write_enable_ref, go, busy}), 64'd0);
        chk("rst_addr", 64'({address_write_cur, address_write_ref}), 64'd0);
        chk("rst_data", data_write_cur | data_write_ref, 64'd0);
        reset = 1'b0;
        @(posedge clk); #1;

        // Straight stream, no bubbles
        clear_mem();
        wc0 = n_wcur; wr0 = n_wref; g0 = n_go;
        pulse_start();
        chk("s1_busy_load", 64'(busy), 64'd1);
        send(0, 1280, 0, 1'b0);
        post_load("s1", 0, wc0, wr0, g0);

        // Valid bytes and start_load while waiting for the engine
        wc0 = n_wcur; wr0 = n_wref; g0 = n_go;
        pix_valid = 1'b1; pix_data = 8'h55;
        for (int i = 0; i < 6; i++) begin
            start_load = (i == 1 || i == 3);
            @(negedge clk);
            chk("s3_ready_low", 64'(pix_ready), 64'd0);
            @(posedge clk); #1;
        end
        start_load = 1'b0; pix_valid = 1'b0;
        chk("s3_no_strobe", 64'((n_wcur - wc0) + (n_wref - wr0)), 64'd0);
        chk("s3_no_go", 64'(n_go - g0), 64'd0);
        chk("s3_busy", 64'(busy), 64'd1);
        me_done = 1'b1;
        @(posedge clk); #1;
        me_done = 1'b0;
        chk("s3_idle", 64'(busy), 64'd0);

        // me_done in IDLE is ignored
        me_done = 1'b1;
        @(posedge clk); #1;
        me_done = 1'b0;
        chk("s5_idle_done", 64'(busy), 64'd0);

        // Random bubbles, plus me_done during LOAD_CUR
        clear_mem();
        wc0 = n_wcur; wr0 = n_wref; g0 = n_go;
        pulse_start();
        send(0, 20, 0, 1'b1);
        me_done = 1'b1;
        @(posedge clk); #1;
        me_done = 1'b0;
        chk("s5_load_done_busy", 64'(busy), 64'd1);
        chk("s5_load_done_ready", 64'(pix_ready), 64'd1);
        send(20, 1280, 0, 1'b1);
        post_load("s2", 0, wc0, wr0, g0);

        // start_load together with me_done: back to IDLE only
        start_load = 1'b1; me_done = 1'b1;
        @(posedge clk); #1;
        start_load = 1'b0; me_done = 1'b0;
        chk("s5_both_idle", 64'(busy), 64'd0);
        repeat (5) @(posedge clk);
        #1;
        chk("s5_stay_idle", 64'(busy), 64'd0);

        // Reset partway through the current block
        pulse_start();
        send(0, 100, 8'h33, 1'b0);
        chk("s4_pre_busy", 64'(busy), 64'd1);
        reset = 1'b1;
        #1;
        chk("s4_rst_ctrl", 64'({pix_ready, write_enable_cur, write_enable_ref, go, busy}), 64'd0);
        chk("s4_rst_addr", 64'({address_write_cur, address_write_ref}), 64'd0);
        chk("s4_rst_data", data_write_cur | data_write_ref, 64'd0);
        chk("s4_sb_empty", 64'(sbq.size()), 64'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;
        clear_mem();
        wc0 = n_wcur; wr0 = n_wref; g0 = n_go;
        pulse_start();
        send(0, 1280, 8'hA0, 1'b0);
        post_load("s4", 8'hA0, wc0, wr0, g0);
        me_done = 1'b1;
        @(posedge clk); #1;
        me_done = 1'b0;
        chk("s4_idle", 64'(busy), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
